ram_port_arbiter: RTL and testbench

//  Shares the single data RAM port between the CPU and one auxiliary master
//  (loader/DMA/display scanner). CPU has priority. Aux gets burst support and
//  a starvation guarantee. Sits between control/xreg/dbus and the ram instance.

---
 rtl/ram_port_arbiter.sv | 130 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single data RAM port between the CPU (priority) and one aux master with bursts.
// Optional ARB_STALL_COUNT_EN adds a saturating cpuStallCount port counting CPU wait cycles.
module ram_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              resetBar,
  input  logic              cpuReq,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWdata,
  output logic              cpuWait,
  output logic [DATA_W-1:0] cpuRdata,
  input  logic              auxValid,
  input  logic              auxWrite,
  input  logic              auxLast,
  input  logic [ADDR_W-1:0] auxAddr,
  input  logic [DATA_W-1:0] auxWdata,
  output logic              auxReady,
  output logic              auxRvalid,
  output logic [DATA_W-1:0] auxRdata,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  output logic              memWe,
  output logic              memRe,
  input  logic [DATA_W-1:0] memRdata,
`ifdef ARB_STALL_COUNT_EN
  output logic [15:0]       cpuStallCount,
`endif
  output logic              stateDbg
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

  typedef enum logic {IDLE = 1'b0, AUX = 1'b1} arbStateT;

  arbStateT      state, stateNext;
  logic [WW-1:0] waitCnt, waitNext;
  logic [BW-1:0] beatCnt, beatNext;
  logic          grantCpu, grantAux;

  assign stateDbg = (state == AUX);

  // Handshake: an aux beat transfers in the cycle where auxValid & auxReady are both high;
  // the CPU is served in any cycle with cpuReq & !cpuWait.
  always_comb begin
    grantCpu = 1'b0;
    grantAux = 1'b0;
    if (state == AUX && auxValid) begin
      if (cpuReq && beatCnt == BURST_LIM) grantCpu = 1'b1;
      else                                grantAux = 1'b1;
    end else if (cpuReq && (!auxValid || waitCnt < WAIT_LIM)) begin
      grantCpu = 1'b1;
    end else if (auxValid) begin
      grantAux = 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    beatNext  = beatCnt;
    waitNext  = waitCnt;
    if (grantAux) begin
      if (auxLast) begin
        stateNext = IDLE;
        beatNext  = '0;
      end else begin
        stateNext = AUX;
        beatNext  = (beatCnt == BURST_LIM) ? beatCnt : beatCnt + BW'(1);
      end
    end else if (grantCpu && state == AUX) begin
      // CPU slot inside an open burst starts a fresh slice; burst stays open.
      beatNext = '0;
    end
    if (grantAux || !auxValid)                    waitNext = '0;
    else if (grantCpu && waitCnt != WAIT_LIM)     waitNext = waitCnt + WW'(1);
  end

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state     <= IDLE;
      waitCnt   <= '0;
      beatCnt   <= '0;
      auxRvalid <= 1'b0;
      auxRdata  <= '0;
    end else begin
      state     <= stateNext;
      waitCnt   <= waitNext;
      beatCnt   <= beatNext;
      auxRvalid <= grantAux && !auxWrite;
      if (grantAux && !auxWrite) auxRdata <= memRdata;
    end
  end

  always_comb begin
    memAddr  = '0;
    memWdata = '0;
    memWe    = 1'b0;
    memRe    = 1'b0;
    if (grantCpu) begin
      memAddr  = cpuAddr;
      memWdata = cpuWdata;
      memWe    = cpuWrite;
      memRe    = !cpuWrite;
    end else if (grantAux) begin
      memAddr  = auxAddr;
      memWdata = auxWdata;
      memWe    = auxWrite;
      memRe    = !auxWrite;
    end
  end

  assign cpuWait  = cpuReq && !grantCpu;
  assign auxReady = grantAux;
  assign cpuRdata = grantCpu ? memRdata : '0;

`ifdef ARB_STALL_COUNT_EN
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar)                            cpuStallCount <= '0;
    else if (cpuWait && cpuStallCount != 16'hFFFF) cpuStallCount <= cpuStallCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM on the mem port.
// Build with +define+ARB_STALL_COUNT_EN to also check cpuStallCount.
module tb_ram_port_arbiter;

  logic       clk, resetBar;
  logic       cpuReq, cpuWrite, cpuWait;
  logic [7:0] cpuAddr, cpuWdata, cpuRdata;
  logic       auxValid, auxWrite, auxLast, auxReady, auxRvalid;
  logic [7:0] auxAddr, auxWdata, auxRdata;
  logic [7:0] memAddr, memWdata, memRdata;
  logic       memWe, memRe, stateDbg;
`ifdef ARB_STALL_COUNT_EN
  logic [15:0] cpuStallCount;
`endif

  logic       ramInit;
  logic [7:0] ram [256];
  int         nCmp, nErr;
  logic [7:0] burstExp [10];

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(4), .BURST_MAX(8)) dut (
    .clk(clk), .resetBar(resetBar),
    .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuWait(cpuWait), .cpuRdata(cpuRdata),
    .auxValid(auxValid), .auxWrite(auxWrite), .auxLast(auxLast), .auxAddr(auxAddr),
    .auxWdata(auxWdata), .auxReady(auxReady), .auxRvalid(auxRvalid), .auxRdata(auxRdata),
    .memAddr(memAddr), .memWdata(memWdata), .memWe(memWe), .memRe(memRe),
    .memRdata(memRdata),
`ifdef ARB_STALL_COUNT_EN
    .cpuStallCount(cpuStallCount),
`endif
    .stateDbg(stateDbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: contents i^C3 except 0x10=A5; synchronous write, combinational read
  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 16) ? 8'hA5 : (8'(i) ^ 8'hC3);
    end else if (memWe) begin
      ram[memAddr] <= memWdata;
    end
  end
  assign memRdata = ram[memAddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    cpuReq = 0; cpuWrite = 0; cpuAddr = 0; cpuWdata = 0;
    auxValid = 0; auxWrite = 0; auxLast = 0; auxAddr = 0; auxWdata = 0;
  endtask

  // CPU hammers while aux holds one single-beat read of 0x30 (RAM=F3)
  task automatic runMaxWait();
    cpuReq = 1; cpuWrite = 0; cpuAddr = 8'h11;
    auxValid = 1; auxWrite = 0; auxLast = 1; auxAddr = 8'h30;
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("mw_cpuWait_c%0d", i), cpuWait, 0);
      check($sformatf("mw_auxReady_c%0d", i), auxReady, 0);
      cycle();
    end
    #2;
    check("mw_cpuWait_c4", cpuWait, 1);
    check("mw_auxReady_c4", auxReady, 1);
    check("mw_memAddr_c4", memAddr, 8'h30);
    cycle();
    auxValid = 0;
    #2;
    check("mw_auxRvalid", auxRvalid, 1);
    check("mw_auxRdata", auxRdata, 8'hF3);
    check("mw_cpuWait_c5", cpuWait, 0);
    cycle();
    cpuReq = 0;
  endtask

  initial begin
    int b;
    logic prevAux, expAux;
    nCmp = 0; nErr = 0;
    burstExp = '{8'hC3, 8'hC2, 8'hC1, 8'hC0, 8'hC7, 8'hC6, 8'hC5, 8'hC4, 8'hCB, 8'hCA};
    idleInputs();
    resetBar = 0; ramInit = 1;
    #2;
    check("rst_state", stateDbg, 0);
    check("rst_auxRvalid", auxRvalid, 0);
    check("rst_auxRdata", auxRdata, 0);
    check("rst_memWe", memWe, 0);
    check("rst_memRe", memRe, 0);
    cycle();
    ramInit = 0;
    cycle();
    resetBar = 1;
    cycle();

    // CPU-only read of 0x10
    cpuReq = 1; cpuAddr = 8'h10;
    #2;
    check("cpu_rd_wait", cpuWait, 0);
    check("cpu_rd_memRe", memRe, 1);
    check("cpu_rd_data", cpuRdata, 8'hA5);
    check("cpu_rd_auxReady", auxReady, 0);
    cycle();

    // aux-only single write 0x20 <= 5A
    cpuReq = 0; auxValid = 1; auxWrite = 1; auxLast = 1; auxAddr = 8'h20; auxWdata = 8'h5A;
    #2;
    check("aux_wr_ready", auxReady, 1);
    check("aux_wr_memWe", memWe, 1);
    check("aux_wr_memAddr", memAddr, 8'h20);
    check("aux_wr_memWdata", memWdata, 8'h5A);
    cycle();
    idleInputs();
    cpuReq = 1; cpuAddr = 8'h20;
    #2;
    check("aux_wr_state", stateDbg, 0);
    check("aux_wr_noRvalid", auxRvalid, 0);
    check("cpu_rd20_data", cpuRdata, 8'h5A);
    cycle();
    idleInputs();

    // starvation bound, three times
    for (int r = 0; r < 3; r++) runMaxWait();
`ifdef ARB_STALL_COUNT_EN
    check("stall_count", cpuStallCount, 3);
`endif

    // 10-beat aux read burst, CPU requests from cycle 2 until served
    b = 0; prevAux = 0;
    for (int c = 0; c < 11; c++) begin
      auxValid = 1; auxWrite = 0; auxAddr = 8'(b); auxLast = (b == 9);
      cpuReq = (c >= 2 && c <= 8); cpuAddr = 8'h20;
      expAux = (c != 8);
      #2;
      check($sformatf("burst_auxReady_c%0d", c), auxReady, expAux);
      check($sformatf("burst_cpuWait_c%0d", c), cpuWait, (c >= 2 && c <= 7));
      check($sformatf("burst_auxRvalid_c%0d", c), auxRvalid, prevAux);
      if (prevAux) check($sformatf("burst_auxRdata_c%0d", c), auxRdata, burstExp[b-1]);
      if (c == 8) begin
        check("burst_state_c8", stateDbg, 1);
        check("burst_cpuRdata_c8", cpuRdata, 8'h5A);
      end
      cycle();
      prevAux = expAux;
      if (expAux) b++;
    end
    idleInputs();
    #2;
    check("burst_end_rvalid", auxRvalid, 1);
    check("burst_end_rdata", auxRdata, 8'hCA);
    check("burst_end_state", stateDbg, 0);
    cycle();
    check("burst_end_pulse", auxRvalid, 0);

    // reset in the middle of a burst
    for (int k = 0; k < 4; k++) begin
      auxValid = 1; auxWrite = 0; auxLast = 0; auxAddr = 8'(k);
      cycle();
    end
    check("mid_state_open", stateDbg, 1);
    check("mid_rvalid_before", auxRvalid, 1);
    resetBar = 0;
    #1;
    check("mid_rst_rvalid", auxRvalid, 0);
    check("mid_rst_state", stateDbg, 0);
    check("mid_rst_rdata", auxRdata, 0);
    #1;
    resetBar = 1;
    auxAddr = 8'h04; cpuReq = 1; cpuAddr = 8'h10;
    #1;
    check("post_rst_cpuWait", cpuWait, 0);
    check("post_rst_auxReady", auxReady, 0);
    check("post_rst_cpuRdata", cpuRdata, 8'hA5);
    cycle();
    idleInputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
